// File: rtl/pcs_deskew_pkg.sv
// Shared state encoding, parameter defaults and helpers for the PCS lane deskew controller.
package pcs_deskew_pkg;

  localparam int unsigned N_LANES_DEF  = 20;
  localparam int unsigned MAX_SKEW_DEF = 64;

  typedef enum logic [3:0] {
    ST_WAIT_LOCK = 4'b0001,
    ST_MEASURE   = 4'b0010,
    ST_ALIGNED   = 4'b0100,
    ST_SKEW_FAIL = 4'b1000
  } deskew_state_e;

  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/skew_window_tracker.sv
// Arrival vector and saturating skew counter for one lane-marker window; flags
// completion, overflow and duplicate markers as lookahead for the current advance.
module skew_window_tracker
  import pcs_deskew_pkg::*;
#(
  parameter int unsigned N_LANES  = N_LANES_DEF,
  parameter int unsigned MAX_SKEW = MAX_SKEW_DEF,
  parameter int unsigned NB_SKEW  = $clog2(MAX_SKEW + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_advance,
  input  logic               i_clear,
  input  logic               i_track,
  input  logic [N_LANES-1:0] i_start_of_lane,
  output logic [NB_SKEW-1:0] o_count,
  output logic               o_all_arrived,
  output logic               o_overflow,
  output logic               o_duplicate
);

  localparam logic [NB_SKEW-1:0] MAX_CNT = NB_SKEW'(MAX_SKEW);

  logic [N_LANES-1:0] arrived_q;
  logic [N_LANES-1:0] arrived_n;
  logic               active_q;
  logic               open_now;
  logic [NB_SKEW-1:0] count_q;

  // o_count is the skew of a lane arriving in this advance (0 on the opening advance).
  always_comb begin
    arrived_n     = arrived_q | i_start_of_lane;
    open_now      = active_q | (|i_start_of_lane);
    o_count       = active_q ? count_q : '0;
    o_all_arrived = open_now & (&arrived_n);
    o_overflow    = open_now & (o_count == MAX_CNT) & ~(&arrived_n);
    o_duplicate   = |(i_start_of_lane & arrived_q);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      arrived_q <= '0;
      active_q  <= 1'b0;
      count_q   <= '0;
    end else if (i_advance) begin
      if (i_clear) begin
        arrived_q <= '0;
        active_q  <= 1'b0;
        count_q   <= '0;
      end else if (i_track && open_now) begin
        arrived_q <= arrived_n;
        active_q  <= 1'b1;
        count_q   <= (o_count == MAX_CNT) ? MAX_CNT : o_count + NB_SKEW'(1);
      end
    end
  end

endmodule

// File: rtl/lane_deskew_ctrl.sv
// PCS lane deskew sequencer: waits for all AM locks, measures marker skew, gates the
// deskew FIFOs and starts the common read. Optional ALIGNED recheck: LANE_DESKEW_RECHECK_EN.
module lane_deskew_ctrl
  import pcs_deskew_pkg::*;
#(
  parameter int unsigned N_LANES  = N_LANES_DEF,
  parameter int unsigned MAX_SKEW = MAX_SKEW_DEF,
  parameter int unsigned NB_SKEW  = $clog2(MAX_SKEW + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [N_LANES-1:0] i_am_lock,
  input  logic [N_LANES-1:0] i_start_of_lane,
  output logic [N_LANES-1:0] o_fifo_wr_en,
  output logic               o_fifo_rd_start,
  output logic               o_align_status,
  output logic               o_resync_all,
  output logic               o_skew_err,
  output logic [NB_SKEW-1:0] o_skew_value
);

  deskew_state_e      state_q;
  deskew_state_e      state_n;
  logic               advance;
  logic               lock_all;
  logic               trk_clear;
  logic               trk_track;
  logic               trk_all;
  logic               trk_ovf;
  logic               trk_dup;
  logic [NB_SKEW-1:0] trk_count;

  assign advance  = i_enable & i_valid;
  assign lock_all = &i_am_lock;

  skew_window_tracker #(
    .N_LANES  (N_LANES),
    .MAX_SKEW (MAX_SKEW),
    .NB_SKEW  (NB_SKEW)
  ) u_tracker (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_advance       (advance),
    .i_clear         (trk_clear),
    .i_track         (trk_track),
    .i_start_of_lane (i_start_of_lane),
    .o_count         (trk_count),
    .o_all_arrived   (trk_all),
    .o_overflow      (trk_ovf),
    .o_duplicate     (trk_dup)
  );

`ifdef LANE_DESKEW_RECHECK_EN
  logic recheck_fail;
  assign recheck_fail = trk_ovf | trk_dup |
                        (trk_all & (abs_diff(32'(trk_count), 32'(o_skew_value)) > 32'd1));
`endif

  // Window is cleared on every advance except while a measurement is still open;
  // lock loss is tested first so it pre-empts completion and failure.
  always_comb begin
    state_n   = state_q;
    trk_track = 1'b0;
    trk_clear = 1'b1;
    unique case (state_q)
      ST_WAIT_LOCK: if (lock_all) state_n = ST_MEASURE;
      ST_MEASURE: begin
        trk_track = 1'b1;
        if (!lock_all)                state_n = ST_WAIT_LOCK;
        else if (trk_ovf || trk_dup)  state_n = ST_SKEW_FAIL;
        else if (trk_all)             state_n = ST_ALIGNED;
        else                          trk_clear = 1'b0;
      end
      ST_ALIGNED: begin
        if (!lock_all) state_n = ST_WAIT_LOCK;
`ifdef LANE_DESKEW_RECHECK_EN
        else begin
          trk_track = 1'b1;
          if (recheck_fail)  state_n = ST_SKEW_FAIL;
          else if (!trk_all) trk_clear = 1'b0;
        end
`endif
      end
      ST_SKEW_FAIL: state_n = ST_WAIT_LOCK;
      default:      state_n = ST_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)      state_q <= ST_WAIT_LOCK;
    else if (advance) state_q <= state_n;
  end

  // Outputs are registered from the next state so each one lands with its state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_fifo_wr_en    <= '0;
      o_fifo_rd_start <= 1'b0;
      o_align_status  <= 1'b0;
      o_resync_all    <= 1'b0;
      o_skew_err      <= 1'b0;
      o_skew_value    <= '0;
    end else if (advance) begin
      o_fifo_rd_start <= (state_q == ST_MEASURE) && (state_n == ST_ALIGNED);
      o_align_status  <= (state_n == ST_ALIGNED);
      o_resync_all    <= (state_n == ST_SKEW_FAIL);
      case (state_n)
        ST_MEASURE: o_fifo_wr_en <= (state_q == ST_MEASURE) ? (o_fifo_wr_en | i_start_of_lane) : '0;
        ST_ALIGNED: o_fifo_wr_en <= '1;
        default:    o_fifo_wr_en <= '0;
      endcase
      if (state_n == ST_SKEW_FAIL)      o_skew_err <= 1'b1;
      else if (state_n == ST_WAIT_LOCK) o_skew_err <= 1'b0;
      if ((state_q == ST_MEASURE) && (state_n == ST_ALIGNED)) o_skew_value <= trk_count;
    end
  end

endmodule

// File: tb/tb_lane_deskew_ctrl.sv
// Scoreboard bench for lane_deskew_ctrl: expected output words are queued as stimulus
// is applied and popped once the registered outputs have settled.
module tb_lane_deskew_ctrl;

  localparam int unsigned N    = 20;
  localparam int unsigned MAXS = 64;
  localparam int unsigned NB   = 7;
  localparam logic [N-1:0] ALL = '1;

  typedef logic [N+NB+3:0] vec_t;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_enable;
  logic          i_valid;
  logic [N-1:0]  i_am_lock;
  logic [N-1:0]  i_start_of_lane;
  logic [N-1:0]  o_fifo_wr_en;
  logic          o_fifo_rd_start;
  logic          o_align_status;
  logic          o_resync_all;
  logic          o_skew_err;
  logic [NB-1:0] o_skew_value;

  vec_t          exp_q[$];
  vec_t          got;
  vec_t          want;
  int unsigned   nvec = 0;
  int unsigned   nerr = 0;
  logic [NB-1:0] last_skew = '0;

  always #5 i_clock = ~i_clock;

  lane_deskew_ctrl #(
    .N_LANES  (N),
    .MAX_SKEW (MAXS)
  ) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_valid         (i_valid),
    .i_am_lock       (i_am_lock),
    .i_start_of_lane (i_start_of_lane),
    .o_fifo_wr_en    (o_fifo_wr_en),
    .o_fifo_rd_start (o_fifo_rd_start),
    .o_align_status  (o_align_status),
    .o_resync_all    (o_resync_all),
    .o_skew_err      (o_skew_err),
    .o_skew_value    (o_skew_value)
  );

  function automatic vec_t outs();
    return {o_fifo_wr_en, o_fifo_rd_start, o_align_status, o_resync_all, o_skew_err, o_skew_value};
  endfunction

  function automatic vec_t mk(input logic [N-1:0] wr, input logic rd, input logic al,
                              input logic rs, input logic er, input logic [NB-1:0] sk);
    return {wr, rd, al, rs, er, sk};
  endfunction

  task automatic cyc(input logic en, input logic vl, input logic [N-1:0] lock, input logic [N-1:0] sol);
    i_enable        = en;
    i_valid         = vl;
    i_am_lock       = lock;
    i_start_of_lane = sol;
    @(posedge i_clock);
    #1;
    i_start_of_lane = '0;
  endtask

  function automatic logic [N-1:0] lane_lost(input int unsigned k);
    logic [N-1:0] v;
    v    = ALL;
    v[k] = 1'b0;
    return v;
  endfunction

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b1; i_am_lock = ALL; i_start_of_lane = ALL;
    repeat (3) @(posedge i_clock);
    #1;
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL reset got=%h want=%h", got, want); end
    i_reset = 1'b0; i_start_of_lane = '0;
  endtask

  task automatic test_sequential();
    logic [N-1:0] acc;
    logic [N-1:0] s;
    acc = '0;
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL seq_enter got=%h want=%h", got, want); end
    for (int k = 0; k < N; k++) begin
      s = '0; s[k] = 1'b1; acc = acc | s;
      if (k == N - 1) exp_q.push_back(mk(ALL, 1'b1, 1'b1, 1'b0, 1'b0, 7'd19));
      else            exp_q.push_back(mk(acc, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
      cyc(1'b1, 1'b1, ALL, s);
      got = outs(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL seq_lane%0d got=%h want=%h", k, got, want); end
    end
    last_skew = 7'd19;
    exp_q.push_back(mk(ALL, 1'b0, 1'b1, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL seq_hold got=%h want=%h", got, want); end
  endtask

  task automatic test_lock_loss();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
      cyc(1'b1, 1'b1, lane_lost(3), '0);
      got = outs(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL lock_loss%0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_simultaneous();
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL simul_enter got=%h want=%h", got, want); end
    exp_q.push_back(mk(ALL, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0));
    cyc(1'b1, 1'b1, ALL, ALL);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL simul_all got=%h want=%h", got, want); end
    last_skew = 7'd0;
    exp_q.push_back(mk(ALL, 1'b0, 1'b1, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL simul_rd_drop got=%h want=%h", got, want); end
  endtask

  task automatic test_valid_gaps();
    logic en;
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, lane_lost(0), '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL gap_unlock got=%h want=%h", got, want); end
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL gap_enter got=%h want=%h", got, want); end
    exp_q.push_back(mk(20'h00001, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, 20'h00001);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL gap_first got=%h want=%h", got, want); end
    for (int j = 1; j <= 4; j++) begin
      en = (j % 2) == 1;
      exp_q.push_back(mk(20'h00001, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
      cyc(en, ~en, ALL, lane_lost(0));
      got = outs(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL gap_idle%0d got=%h want=%h", j, got, want); end
      if (j == 4) exp_q.push_back(mk(ALL, 1'b1, 1'b1, 1'b0, 1'b0, 7'd4));
      else        exp_q.push_back(mk(20'h00001, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
      cyc(1'b1, 1'b1, ALL, (j == 4) ? lane_lost(0) : '0);
      got = outs(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL gap_adv%0d got=%h want=%h", j, got, want); end
    end
    last_skew = 7'd4;
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back(mk(ALL, 1'b1, 1'b1, 1'b0, 1'b0, last_skew));
      cyc(j == 1, j == 0, ALL, '0);
      got = outs(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL gap_stretch%0d got=%h want=%h", j, got, want); end
    end
    exp_q.push_back(mk(ALL, 1'b0, 1'b1, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL gap_rd_drop got=%h want=%h", got, want); end
  endtask

`ifdef LANE_DESKEW_RECHECK_EN
  task automatic test_recheck();
    int unsigned dist [3] = '{5, 6, 9};
    for (int p = 0; p < 3; p++) begin
      if (p == 0) begin
        exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
        cyc(1'b1, 1'b1, lane_lost(1), '0);
        got = outs(); want = exp_q.pop_front(); nvec++;
        if (got !== want) begin nerr++; $display("FAIL rchk_unlock got=%h want=%h", got, want); end
        exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
        cyc(1'b1, 1'b1, ALL, '0);
        got = outs(); want = exp_q.pop_front(); nvec++;
        if (got !== want) begin nerr++; $display("FAIL rchk_enter got=%h want=%h", got, want); end
      end
      for (int d = 0; d <= int'(dist[p]); d++) begin
        if (p == 0)
          exp_q.push_back((d == int'(dist[p])) ? mk(ALL, 1'b1, 1'b1, 1'b0, 1'b0, 7'd5)
                                               : mk(20'h00001, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
        else if (p == 2 && d == int'(dist[p]))
          exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd5));
        else
          exp_q.push_back(mk(ALL, 1'b0, 1'b1, 1'b0, 1'b0, 7'd5));
        cyc(1'b1, 1'b1, ALL, (d == 0) ? 20'h00001 : ((d == int'(dist[p])) ? lane_lost(0) : '0));
        got = outs(); want = exp_q.pop_front(); nvec++;
        if (got !== want) begin nerr++; $display("FAIL rchk_p%0d_d%0d got=%h want=%h", p, d, got, want); end
      end
      if (p == 0) last_skew = 7'd5;
    end
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL rchk_exit got=%h want=%h", got, want); end
  endtask
`else
  task automatic test_aligned_sol();
    logic [N-1:0] pat [3] = '{20'h00020, 20'hF0F0F, ALL};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(ALL, 1'b0, 1'b1, 1'b0, 1'b0, last_skew));
      cyc(1'b1, 1'b1, ALL, pat[i]);
      got = outs(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL aligned_sol%0d got=%h want=%h", i, got, want); end
    end
  endtask
`endif

  task automatic test_skew_fail();
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, lane_lost(12), '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL sf_unlock got=%h want=%h", got, want); end
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL sf_enter got=%h want=%h", got, want); end
    exp_q.push_back(mk(lane_lost(7), 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, lane_lost(7));
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL sf_open got=%h want=%h", got, want); end
    for (int i = 1; i <= int'(MAXS); i++) begin
      if (i == int'(MAXS)) exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, 1'b1, last_skew));
      else                 exp_q.push_back(mk(lane_lost(7), 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
      cyc(1'b1, 1'b1, ALL, '0);
      got = outs(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL sf_cnt%0d got=%h want=%h", i, got, want); end
    end
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL sf_exit got=%h want=%h", got, want); end
  endtask

  task automatic test_duplicate();
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL dup_enter got=%h want=%h", got, want); end
    exp_q.push_back(mk(20'h00004, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, 20'h00004);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL dup_first got=%h want=%h", got, want); end
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, 1'b1, last_skew));
    cyc(1'b1, 1'b1, ALL, 20'h00014);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL dup_repeat got=%h want=%h", got, want); end
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL dup_exit got=%h want=%h", got, want); end
  endtask

  task automatic test_async_reset();
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL ar_enter got=%h want=%h", got, want); end
    exp_q.push_back(mk(20'h003FF, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, 20'h003FF);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL ar_half got=%h want=%h", got, want); end
    #1; i_reset = 1'b1; #1;
    last_skew = '0;
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL ar_immediate got=%h want=%h", got, want); end
    #1; i_reset = 1'b0;
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, '0);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL ar_reenter got=%h want=%h", got, want); end
    exp_q.push_back(mk(20'hFFC00, 1'b0, 1'b0, 1'b0, 1'b0, last_skew));
    cyc(1'b1, 1'b1, ALL, 20'hFFC00);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL ar_upper got=%h want=%h", got, want); end
    exp_q.push_back(mk(ALL, 1'b1, 1'b1, 1'b0, 1'b0, 7'd1));
    cyc(1'b1, 1'b1, ALL, 20'h003FF);
    got = outs(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL ar_lower got=%h want=%h", got, want); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d vectors", nvec);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_lock_loss();
    test_simultaneous();
    test_valid_gaps();
`ifdef LANE_DESKEW_RECHECK_EN
    test_recheck();
`else
    test_aligned_sol();
`endif
    test_skew_fail();
    test_duplicate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lane_deskew_ctrl.md
# lane_deskew_ctrl

- Sequences PCS lane deskew once every lane's alignment-marker lock FSM reports lock.
- Measures inter-lane skew from the per-lane start-of-lane pulses and enables each lane's deskew FIFO write on its own marker.
- Starts the common FIFO read once the last lane arrives, then asserts alignment status.
- Sits between the 20 per-lane AM lock FSMs and the deskew FIFO bank / reorder stage.

## Interface
Parameters:
- N_LANES, 20, number of PCS lanes.
- MAX_SKEW, 64, max tolerated skew in valid cycles between first and last lane marker.
- NB_SKEW, $clog2(MAX_SKEW+1), skew counter width.

Ports:
- Clock/reset: one clock; reset is asynchronous and active-high.
  - i_clock  in  1  block clock.
  - i_reset  in  1  asynchronous active-high reset.
- i_enable  in  1  block enable; FSM frozen when 0.
- i_valid  in  1  datapath valid; counters and FSM advance only when i_enable && i_valid.
- i_am_lock  in  N_LANES  per-lane AM lock.
- i_start_of_lane  in  N_LANES  per-lane one-cycle SOL pulse.
- o_fifo_wr_en  out  N_LANES  per-lane deskew FIFO write enable (level).
- o_fifo_rd_start  out  1  one-cycle pulse that starts common FIFO read.
- o_align_status  out  1  all lanes locked and deskewed.
- o_resync_all  out  1  one-cycle pulse forcing all lane lock FSMs back to WAIT_1ST.
- o_skew_err  out  1  sticky skew error; cleared on entry to WAIT_LOCK.
- o_skew_value  out  NB_SKEW  last measured skew (first-to-last arrival).

## Operation
- Advance means an i_enable && i_valid cycle; otherwise all state, counters and outputs hold. Pulses are stretched until the next advance.
- FSM states are one-hot: WAIT_LOCK, MEASURE, ALIGNED, SKEW_FAIL.
- WAIT_LOCK:
  - o_fifo_wr_en = 0, o_align_status = 0, arrival vector cleared.
  - When &i_am_lock, go to MEASURE.
- MEASURE:
  - The window opens on the first advance with any i_start_of_lane bit set; the skew counter starts at 0 and increments once per advance, saturating at MAX_SKEW.
  - Each arriving lane sets its arrival bit and its o_fifo_wr_en bit.
  - When the arrival vector is all ones: o_skew_value = counter, pulse o_fifo_rd_start, go to ALIGNED.
  - Counter == MAX_SKEW with lanes still missing: go to SKEW_FAIL.
  - A repeated SOL from an already-arrived lane inside the window: go to SKEW_FAIL.
  - Any i_am_lock bit low: go to WAIT_LOCK, no error.
- ALIGNED:
  - o_align_status = 1; o_fifo_wr_en stays all ones.
  - Any i_am_lock bit low: go to WAIT_LOCK.
- SKEW_FAIL:
  - Set o_skew_err, pulse o_resync_all, clear o_fifo_wr_en.
  - Unconditionally go to WAIT_LOCK on the next advance.
- Simultaneous SOL on all lanes in one advance: skew = 0, go straight to ALIGNED.
- Lock loss has priority over completion or failure in the same advance.

## Timing
- Reset values: FSM = WAIT_LOCK, o_fifo_wr_en = 0, o_fifo_rd_start = 0, o_align_status = 0, o_resync_all = 0, o_skew_err = 0, o_skew_value = 0, counter = 0.
- All outputs are registered. An o_fifo_wr_en bit rises in the cycle after the advance that sampled its SOL.
- o_fifo_rd_start and o_align_status rise in the cycle after the last arrival is sampled.
- Lock loss drops o_align_status and o_fifo_wr_en one cycle after the sampling advance.
- Asynchronous reset mid-MEASURE clears the window immediately.

## Configuration
- LANE_DESKEW_RECHECK_EN defined: in ALIGNED, every SOL set reopens a check window using the same counter and rules.
  - Skew > MAX_SKEW, or any lane's arrival changing by more than 1 from the stored o_skew_value, goes to SKEW_FAIL.
  - o_align_status drops with o_resync_all.
- Undefined: ALIGNED exits only on lock loss; SOL pulses in ALIGNED are ignored.

## Structure
- Shared package pcs_deskew_pkg holds:
  - the state one-hot localparams;
  - the N_LANES default (20);
  - the MAX_SKEW default.
- One sub-module, skew_window_tracker, holds the arrival vector, saturating skew counter, all-arrived, overflow and duplicate flags. It is reused by MEASURE and by the recheck path.

## Test plan
- Reset, then all locks high; SOL on lanes 0..19 one lane per valid cycle -> wr_en bits rise one by one, rd_start pulses once, o_skew_value = 19, align_status = 1.
- All 20 SOL bits in the same cycle -> o_skew_value = 0, rd_start one cycle later.
- MAX_SKEW = 64, lane 7 never sends SOL -> SKEW_FAIL after 64 valid cycles, resync_all pulse, skew_err = 1, wr_en = 0.
- ALIGNED, drop i_am_lock[3] -> align_status = 0 and wr_en = 0 next cycle, return to WAIT_LOCK, skew_err unchanged.
- i_valid toggling 1/0 during MEASURE -> counter advances only on valid cycles; skew equals the valid-cycle distance.
- With LANE_DESKEW_RECHECK_EN: after lock with skew 5, next period shows skew 9 -> SKEW_FAIL and resync_all pulse.
